// File: rtl/smem_pkg.sv
// Shared definitions for the backward-extension pipeline: stage status codes,
// curr-queue entry layout and the ambiguous-base character.
package smem_pkg;

  // One-hot stage status; all-zero marks an empty slot.
  localparam logic [5:0] BUBBLE  = 6'b000000;
  localparam logic [5:0] F_INIT  = 6'b000001;
  localparam logic [5:0] F_RUN   = 6'b000010;
  localparam logic [5:0] F_BREAK = 6'b000100;
  localparam logic [5:0] BCK_INI = 6'b001000;
  localparam logic [5:0] BCK_RUN = 6'b010000;
  localparam logic [5:0] BCK_END = 6'b100000;

  // Sideband {primary[63:0], min_intv[6:0], new_size[6:0], new_last_size[6:0],
  //           finish_sign, iteration_boundary}
  localparam int unsigned SIDE_W = 87;

  localparam logic [7:0] BASE_AMBIG = 8'd4;

  typedef struct packed {
    logic [63:0] info;
    logic [63:0] x2;
    logic [63:0] x1;
    logic [63:0] x0;
  } curr_t;

  // Characters above 3 are not A/C/G/T and collapse to the ambiguous code.
  function automatic logic [7:0] base_char(input logic ambig, input logic [7:0] raw);
    return (ambig || (raw > 8'd3)) ? BASE_AMBIG : raw;
  endfunction

endpackage

// File: rtl/bck_rd_hold.sv
// Return-path selector for one synchronous-read RAM port: keeps the read data
// alive across a stall and substitutes same-cycle write data when bypassed.
module bck_rd_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             byp_en,
  input  logic [WIDTH-1:0] byp_data,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] data_out
);

  logic             fresh_q, fresh_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             byp_v_q, byp_v_d;
  logic [WIDTH-1:0] byp_q, byp_d;

  // fresh_q: RAM output this cycle belongs to the read issued last cycle.
  // Only that cycle's data is worth holding; later stall cycles see other addresses.
  always_comb begin
    fresh_d  = ~stall;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    byp_v_d  = byp_v_q;
    byp_d    = byp_q;
    if (!stall) begin
      hold_v_d = 1'b0;
      byp_v_d  = byp_en;
      byp_d    = byp_en ? byp_data : '0;
    end else if (fresh_q) begin
      hold_v_d = 1'b1;
      hold_d   = rd_data;
    end
  end

  // State update with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fresh_q  <= 1'b0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      byp_v_q  <= 1'b0;
      byp_q    <= '0;
    end else begin
      fresh_q  <= fresh_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
      byp_v_q  <= byp_v_d;
      byp_q    <= byp_d;
    end
  end

  assign data_out = byp_v_q ? byp_q : (hold_v_q ? hold_q : rd_data);

endmodule

// File: rtl/bck_fetch_stage3.sv
// Backward-extension fetch stage: issues curr-queue and read-base reads for
// each BCK token and returns the fetched data aligned with its sidebands.
module bck_fetch_stage3
  import smem_pkg::*;
#(
  parameter int unsigned READ_NUM_WIDTH = 10,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned CURR_W         = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [5:0]                  status_in,
  input  logic [READ_NUM_WIDTH-1:0]   read_num_in,
  input  logic [ADDR_W-1:0]           rd_addr_in,
  input  logic [ADDR_W-1:0]           bck_i_in,
  input  logic [ADDR_W-1:0]           bck_j_in,
  input  logic [SIDE_W-1:0]           side_in,
  output logic [ADDR_W-1:0]           cq_rd_addr,
  input  logic [CURR_W-1:0]           cq_rd_data,
  input  logic                        cq_wr_en,
  input  logic [ADDR_W-1:0]           cq_wr_addr,
  input  logic [CURR_W-1:0]           cq_wr_data,
  output logic [READ_NUM_WIDTH+ADDR_W-1:0] base_rd_addr,
  input  logic [7:0]                  base_rd_data,
  output logic [5:0]                  status_out,
  output logic [CURR_W-1:0]           curr_out,
  output logic [7:0]                  output_c,
  output logic [SIDE_W-1:0]           side_out,
  output logic [READ_NUM_WIDTH-1:0]   read_num_out,
  output logic [ADDR_W-1:0]           bck_i_out,
  output logic [ADDR_W-1:0]           bck_j_out
);

  logic is_run, is_ini, take, byp_en;
  logic [ADDR_W-1:0] base_pos;

  // Stage A: token captured alongside the RAM reads it issued.
  logic [5:0]                a_status_q, a_status_d;
  logic [READ_NUM_WIDTH-1:0] a_read_num_q, a_read_num_d;
  logic [ADDR_W-1:0]         a_bck_i_q, a_bck_i_d;
  logic [ADDR_W-1:0]         a_bck_j_q, a_bck_j_d;
  logic [SIDE_W-1:0]         a_side_q, a_side_d;
  logic                      a_live_q, a_live_d;
  logic                      a_ambig_q, a_ambig_d;

  // Stage B: registered outputs.
  logic [5:0]                b_status_q, b_status_d;
  logic [CURR_W-1:0]         b_curr_q, b_curr_d;
  logic [7:0]                b_c_q, b_c_d;
  logic [SIDE_W-1:0]         b_side_q, b_side_d;
  logic [READ_NUM_WIDTH-1:0] b_read_num_q, b_read_num_d;
  logic [ADDR_W-1:0]         b_bck_i_q, b_bck_i_d;
  logic [ADDR_W-1:0]         b_bck_j_q, b_bck_j_d;

  logic [CURR_W-1:0] curr_fetch;
  logic [7:0]        base_fetch;

  // Read issue: addresses come straight from the incoming token.
  always_comb begin
    is_run     = (status_in == BCK_RUN);
    is_ini     = (status_in == BCK_INI);
    take       = is_run | is_ini;
    base_pos   = (bck_i_in != '0) ? (bck_i_in - ADDR_W'(1)) : '0;
    cq_rd_addr   = rd_addr_in;
    base_rd_addr = {read_num_in, base_pos};
    // RAM returns old data on read-during-write, so forward the write here.
    byp_en     = is_run & cq_wr_en & (cq_wr_addr == rd_addr_in);
  end

  // Stage A next state: non-BCK tokens collapse to an all-zero bubble.
  always_comb begin
    a_status_d   = a_status_q;
    a_read_num_d = a_read_num_q;
    a_bck_i_d    = a_bck_i_q;
    a_bck_j_d    = a_bck_j_q;
    a_side_d     = a_side_q;
    a_live_d     = a_live_q;
    a_ambig_d    = a_ambig_q;
    if (!stall) begin
      a_status_d   = take ? status_in : BUBBLE;
      a_read_num_d = take ? read_num_in : '0;
      a_bck_i_d    = take ? bck_i_in : '0;
      a_bck_j_d    = take ? bck_j_in : '0;
      a_side_d     = take ? side_in : '0;
      a_live_d     = is_run;
      a_ambig_d    = take & ((bck_i_in == '0) | side_in[0]);
    end
  end

  // Stage B next state: only live reads use RAM data; INI yields zeros.
  always_comb begin
    b_status_d   = b_status_q;
    b_curr_d     = b_curr_q;
    b_c_d        = b_c_q;
    b_side_d     = b_side_q;
    b_read_num_d = b_read_num_q;
    b_bck_i_d    = b_bck_i_q;
    b_bck_j_d    = b_bck_j_q;
    if (!stall) begin
      b_status_d   = a_status_q;
      b_curr_d     = a_live_q ? curr_fetch : '0;
      b_c_d        = a_live_q ? base_char(a_ambig_q, base_fetch) : 8'd0;
      b_side_d     = a_side_q;
      b_read_num_d = a_read_num_q;
      b_bck_i_d    = a_bck_i_q;
      b_bck_j_d    = a_bck_j_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_status_q   <= BUBBLE;
      a_read_num_q <= '0;
      a_bck_i_q    <= '0;
      a_bck_j_q    <= '0;
      a_side_q     <= '0;
      a_live_q     <= 1'b0;
      a_ambig_q    <= 1'b0;
      b_status_q   <= BUBBLE;
      b_curr_q     <= '0;
      b_c_q        <= 8'd0;
      b_side_q     <= '0;
      b_read_num_q <= '0;
      b_bck_i_q    <= '0;
      b_bck_j_q    <= '0;
    end else begin
      a_status_q   <= a_status_d;
      a_read_num_q <= a_read_num_d;
      a_bck_i_q    <= a_bck_i_d;
      a_bck_j_q    <= a_bck_j_d;
      a_side_q     <= a_side_d;
      a_live_q     <= a_live_d;
      a_ambig_q    <= a_ambig_d;
      b_status_q   <= b_status_d;
      b_curr_q     <= b_curr_d;
      b_c_q        <= b_c_d;
      b_side_q     <= b_side_d;
      b_read_num_q <= b_read_num_d;
      b_bck_i_q    <= b_bck_i_d;
      b_bck_j_q    <= b_bck_j_d;
    end
  end

  bck_rd_hold #(
    .WIDTH (CURR_W)
  ) u_curr_hold (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .byp_en   (byp_en),
    .byp_data (cq_wr_data),
    .rd_data  (cq_rd_data),
    .data_out (curr_fetch)
  );

  // The base RAM has no write port here, so its bypass is tied off.
  bck_rd_hold #(
    .WIDTH (8)
  ) u_base_hold (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .byp_en   (1'b0),
    .byp_data (8'd0),
    .rd_data  (base_rd_data),
    .data_out (base_fetch)
  );

  assign status_out   = b_status_q;
  assign curr_out     = b_curr_q;
  assign output_c     = b_c_q;
  assign side_out     = b_side_q;
  assign read_num_out = b_read_num_q;
  assign bck_i_out    = b_bck_i_q;
  assign bck_j_out    = b_bck_j_q;

endmodule

// File: tb/tb_bck_fetch_stage3.sv
// Bench for bck_fetch_stage3: external RAM models, a token-level expected-value
// pipeline, and directed plus random stimulus.
module tb_bck_fetch_stage3;
  import smem_pkg::*;

  localparam int unsigned RNW = 10;
  localparam int unsigned AW  = 7;
  localparam int unsigned CW  = 256;
  localparam int unsigned BAW = RNW + AW;

  logic            clk, rst, stall;
  logic [5:0]      status_in;
  logic [RNW-1:0]  read_num_in;
  logic [AW-1:0]   rd_addr_in, bck_i_in, bck_j_in;
  logic [SIDE_W-1:0] side_in;
  logic [AW-1:0]   cq_rd_addr;
  logic [CW-1:0]   cq_rd_data;
  logic            cq_wr_en;
  logic [AW-1:0]   cq_wr_addr;
  logic [CW-1:0]   cq_wr_data;
  logic [BAW-1:0]  base_rd_addr;
  logic [7:0]      base_rd_data;
  logic [5:0]      status_out;
  logic [CW-1:0]   curr_out;
  logic [7:0]      output_c;
  logic [SIDE_W-1:0] side_out;
  logic [RNW-1:0]  read_num_out;
  logic [AW-1:0]   bck_i_out, bck_j_out;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  bck_fetch_stage3 #(
    .READ_NUM_WIDTH (RNW),
    .ADDR_W         (AW),
    .CURR_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .status_in    (status_in),
    .read_num_in  (read_num_in),
    .rd_addr_in   (rd_addr_in),
    .bck_i_in     (bck_i_in),
    .bck_j_in     (bck_j_in),
    .side_in      (side_in),
    .cq_rd_addr   (cq_rd_addr),
    .cq_rd_data   (cq_rd_data),
    .cq_wr_en     (cq_wr_en),
    .cq_wr_addr   (cq_wr_addr),
    .cq_wr_data   (cq_wr_data),
    .base_rd_addr (base_rd_addr),
    .base_rd_data (base_rd_data),
    .status_out   (status_out),
    .curr_out     (curr_out),
    .output_c     (output_c),
    .side_out     (side_out),
    .read_num_out (read_num_out),
    .bck_i_out    (bck_i_out),
    .bck_j_out    (bck_j_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAMs: synchronous read, old data on read-during-write.
  logic [CW-1:0] cq_mem [0:(1<<AW)-1];
  logic [7:0]    base_mem [0:(1<<BAW)-1];

  always @(posedge clk) begin
    cq_rd_data   <= cq_mem[cq_rd_addr];
    base_rd_data <= base_mem[base_rd_addr];
    if (cq_wr_en) cq_mem[cq_wr_addr] <= cq_wr_data;
  end

  // Expected output of a token, fixed at the moment it is accepted.
  typedef struct packed {
    logic [5:0]        st;
    logic [CW-1:0]     curr;
    logic [7:0]        c;
    logic [SIDE_W-1:0] side;
    logic [RNW-1:0]    rn;
    logic [AW-1:0]     bi;
    logic [AW-1:0]     bj;
  } exp_t;

  exp_t exp_a, exp_b;

  function automatic exp_t model_tok();
    exp_t e;
    logic [AW-1:0] pos;
    logic [7:0] b;
    e = '0;
    if (status_in == BCK_RUN || status_in == BCK_INI) begin
      e.st   = status_in;
      e.side = side_in;
      e.rn   = read_num_in;
      e.bi   = bck_i_in;
      e.bj   = bck_j_in;
      if (status_in == BCK_RUN) begin
        e.curr = (cq_wr_en && cq_wr_addr == rd_addr_in) ? cq_wr_data : cq_mem[rd_addr_in];
        pos = (bck_i_in == 0) ? 7'd0 : bck_i_in - 7'd1;
        b = base_mem[{read_num_in, pos}];
        e.c = (bck_i_in == 0 || side_in[0] || b > 8'd3) ? 8'd4 : b;
      end
    end
    return e;
  endfunction

  // Two accepted tokens in flight; stalls freeze both.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_a <= '0;
      exp_b <= '0;
    end else if (!stall) begin
      exp_b <= exp_a;
      exp_a <= model_tok();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [AW-1:0] pos;
      checks++;
      if ({status_out, curr_out, output_c, side_out, read_num_out, bck_i_out, bck_j_out}
          !== exp_b) begin
        errors++;
        $display("FAIL model t=%0t st=%h/%h c=%h/%h rn=%h/%h bi=%h/%h bj=%h/%h curr=%h/%h",
                 $time, status_out, exp_b.st, output_c, exp_b.c, read_num_out, exp_b.rn,
                 bck_i_out, exp_b.bi, bck_j_out, exp_b.bj, curr_out, exp_b.curr);
      end
      pos = (bck_i_in == 0) ? 7'd0 : bck_i_in - 7'd1;
      checks++;
      if (cq_rd_addr !== rd_addr_in || base_rd_addr !== {read_num_in, pos}) begin
        errors++;
        $display("FAIL addr t=%0t cq=%h/%h base=%h/%h", $time, cq_rd_addr, rd_addr_in,
                 base_rd_addr, {read_num_in, pos});
      end
    end
  end

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tok(input logic [5:0] st, input logic [RNW-1:0] rn, input logic [AW-1:0] ra,
                     input logic [AW-1:0] bi, input logic [AW-1:0] bj,
                     input logic [SIDE_W-1:0] sd);
    status_in   = st;
    read_num_in = rn;
    rd_addr_in  = ra;
    bck_i_in    = bi;
    bck_j_in    = bj;
    side_in     = sd;
  endtask

  task automatic idle();
    tok(BUBBLE, '0, '0, '0, '0, '0);
    cq_wr_en = 1'b0;
  endtask

  function automatic logic [CW-1:0] rand256();
    logic [CW-1:0] v;
    for (int k = 0; k < CW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  curr_t xv, yv, zv;
  logic [SIDE_W-1:0] side_a, side_ib;

  initial begin
    xv = '{info: 64'h1111_2222_3333_4444, x2: 64'h5555_6666_7777_8888,
           x1: 64'h9999_aaaa_bbbb_cccc, x0: 64'hdddd_eeee_ffff_0001};
    yv = '{info: 64'hdead_beef_0000_0001, x2: 64'h2, x1: 64'h3, x0: 64'h4};
    zv = '{info: 64'hc0ff_ee00_0000_0000, x2: 64'h7, x1: 64'h8, x0: 64'h9};
    side_a  = {64'h0123_4567_89ab_cdef, 7'd11, 7'd22, 7'd33, 1'b1, 1'b0};
    side_ib = {64'h0, 7'd1, 7'd2, 7'd3, 1'b0, 1'b1};
    for (int a = 0; a < (1 << BAW); a++) base_mem[a] = 8'($urandom_range(0, 7));
    base_mem[{10'd1, 7'd2}] = 8'd2;
    base_mem[{10'd2, 7'd9}] = 8'd7;

    rst = 1'b1;
    stall = 1'b0;
    idle();
    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    // Preload the curr queue through its write port while held in reset.
    for (int a = 0; a < (1 << AW); a++) begin
      cq_wr_en = 1'b1;
      cq_wr_addr = 7'(a);
      cq_wr_data = (a == 5) ? CW'(xv) : rand256();
      step();
    end
    idle();
    chk("rst_status", 256'(status_out), 256'(BUBBLE));
    chk("rst_curr", curr_out, '0);
    rst = 1'b1;
    step();

    // Plain BCK_RUN read.
    tok(BCK_RUN, 10'd1, 7'd5, 7'd3, 7'd9, side_a);
    step();
    idle();
    step();
    chk("run_status", 256'(status_out), 256'(BCK_RUN));
    chk("run_curr", curr_out, CW'(xv));
    chk("run_c", 256'(output_c), 256'd2);
    chk("run_side", 256'(side_out), 256'(side_a));

    // Same-cycle write to the read address is forwarded.
    tok(BCK_RUN, 10'd1, 7'd5, 7'd3, 7'd9, side_a);
    cq_wr_en = 1'b1;
    cq_wr_addr = 7'd5;
    cq_wr_data = CW'(yv);
    step();
    idle();
    step();
    chk("byp_curr", curr_out, CW'(yv));
    chk("byp_c", 256'(output_c), 256'd2);

    // Stall straight after issue with a write to the pending address.
    cq_wr_en = 1'b1;
    cq_wr_addr = 7'd5;
    cq_wr_data = CW'(xv);
    step();
    idle();
    tok(BCK_RUN, 10'd1, 7'd5, 7'd3, 7'd9, side_a);
    step();
    idle();
    stall = 1'b1;
    cq_wr_en = 1'b1;
    cq_wr_addr = 7'd5;
    cq_wr_data = CW'(zv);
    step();
    cq_wr_en = 1'b0;
    step();
    step();
    chk("stall_status", 256'(status_out), 256'(BUBBLE));
    stall = 1'b0;
    step();
    chk("hold_status", 256'(status_out), 256'(BCK_RUN));
    chk("hold_curr", curr_out, CW'(xv));
    chk("hold_c", 256'(output_c), 256'd2);

    // Ambiguous base cases and the INI token.
    tok(BCK_RUN, 10'd1, 7'd5, 7'd0, 7'd9, side_a);
    step();
    tok(BCK_RUN, 10'd2, 7'd5, 7'd10, 7'd9, side_a);
    step();
    chk("bi0_c", 256'(output_c), 256'd4);
    tok(BCK_INI, 10'd1, 7'd5, 7'd3, 7'd9, side_a);
    step();
    chk("amb7_c", 256'(output_c), 256'd4);
    tok(BCK_RUN, 10'd1, 7'd5, 7'd3, 7'd9, side_ib);
    step();
    chk("ini_status", 256'(status_out), 256'(BCK_INI));
    chk("ini_curr", curr_out, '0);
    chk("ini_c", 256'(output_c), 256'd0);
    chk("ini_side", 256'(side_out), 256'(side_a));
    tok(F_RUN, 10'd1, 7'd5, 7'd3, 7'd9, side_a);
    step();
    chk("ib_c", 256'(output_c), 256'd4);
    idle();
    step();
    chk("frun_status", 256'(status_out), 256'(BUBBLE));
    chk("frun_side", 256'(side_out), '0);
    chk("frun_rn", 256'(read_num_out), '0);

    // Random mix with stalls, colliding writes and a reset during a stall.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: status_in = BCK_RUN;
        3:       status_in = BCK_INI;
        4:       status_in = F_RUN;
        5:       status_in = F_INIT;
        6:       status_in = BCK_END;
        default: status_in = F_BREAK;
      endcase
      read_num_in = RNW'($urandom_range(0, 3));
      rd_addr_in  = AW'($urandom_range(0, 7));
      bck_i_in    = ($urandom_range(0, 5) == 0) ? 7'd0 : AW'($urandom());
      bck_j_in    = AW'($urandom());
      side_in     = SIDE_W'({$urandom(), $urandom(), $urandom()});
      cq_wr_en    = ($urandom_range(0, 1) == 1);
      cq_wr_addr  = AW'($urandom_range(0, 7));
      cq_wr_data  = rand256();
      stall       = ($urandom_range(0, 3) == 0);
      if (i == 298) begin
        status_in = BCK_RUN;
        stall = 1'b0;
      end
      if (i == 299) stall = 1'b1;
      if (i == 300) begin
        stall = 1'b1;
        rst = 1'b0;
        #1;
        chk("mid_rst_status", 256'(status_out), 256'(BUBBLE));
        chk("mid_rst_curr", curr_out, '0);
        chk("mid_rst_c", 256'(output_c), '0);
        chk("mid_rst_hold_v", 256'(dut.u_curr_hold.hold_v_q), '0);
      end else begin
        rst = 1'b1;
      end
      step();
    end
    stall = 1'b0;
    rst = 1'b1;
    idle();
    step();
    step();
    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
